mem_bus_responder: RTL and testbench
====================================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter WAIT_CYC, default 2, SHALL set the wait states inserted between request capture and acknowledge (range 0..15).
REQ-002 Parameter DEPTH_LOG2, default 6, SHALL set the word RAM depth to 2**DEPTH_LOG2 32-bit words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  1  SHALL be the initiator request; four-phase, held until ack seen.
REQ-006 we  input  1  SHALL select store (1) or load (0); sampled with req.
REQ-007 addr  input  32  SHALL be the selected load/store byte address; sampled with req.
REQ-008 wdata  input  32  SHALL be store data; sampled with req.
REQ-009 ack  output  1  SHALL pulse high for exactly one cycle per completed transfer.
REQ-010 err  output  1  SHALL be high in the ack cycle when the transfer was rejected.
REQ-011 rdata  output  32  SHALL carry load data, valid in the ack cycle and held until the next ack.
REQ-012 busy  output  1  SHALL be high from request capture until the return to IDLE.

Function
REQ-013 State machine SHALL have states IDLE, WAIT, ACK, DONE.
REQ-014 IDLE: on req=1, capture we/addr/wdata, load the wait counter with WAIT_CYC, and enter WAIT (or ACK when WAIT_CYC=0).
REQ-015 WAIT: decrement the counter each cycle; enter ACK when the counter reaches 1.
REQ-016 Latency: req first sampled high at edge N SHALL give ack high in cycle N+1+WAIT_CYC.
REQ-017 ACK: assert ack one cycle; enter DONE.
REQ-018 DONE: hold ack=0; return to IDLE only after req is sampled low; a req still high SHALL NOT start a new transfer.
REQ-019 Error: err=1 when addr[1:0]!=0 (misaligned) or addr[31:DEPTH_LOG2+2]!=0 (out of range).
REQ-020 Store: write wdata to word addr[DEPTH_LOG2+1:2] in the ACK cycle, only when err=0.
REQ-021 Load: rdata SHALL take the addressed word in the ACK cycle; on err, rdata SHALL be 32'h0000_0000.
REQ-022 Changes on addr/we/wdata after capture SHALL NOT affect the transfer in progress.
REQ-023 A store followed by a load to the same word SHALL return the stored value (no stale read).
REQ-024 req dropped before ack (protocol violation) SHALL NOT abort the transfer; ack still issues, then IDLE.

Reset
REQ-025 rst=1 SHALL force state IDLE, ack=0, err=0, busy=0, rdata=0 and counter=0 on the next edge.
REQ-026 rst during WAIT or ACK SHALL abort the transfer with no RAM write and no ack.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 rst and req high in the same cycle: reset wins; req is not captured.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit typedef), the default WAIT_CYC, and the error-check mask width constants.
REQ-030 The word storage SHALL be a sub-module mem_word_ram (single-port, synchronous write, parameterised by DEPTH_LOG2); control and counter stay in the top module.

Verification
REQ-031 Store addr=0x0000_0010 wdata=0xDEAD_BEEF then load 0x10 -> load ack at N+3, err=0, rdata=0xDEAD_BEEF.
REQ-032 Load addr=0x0000_0102 -> ack with err=1, rdata=0, no RAM change.
REQ-033 Store addr=0x0000_0400 (DEPTH_LOG2=6) -> err=1; later load of word 0 returns its prior value.
REQ-034 WAIT_CYC=0, back-to-back four-phase loads -> each ack at N+1, exactly one ack per req high phase.
REQ-035 rst pulsed one cycle into WAIT of a store to 0x20 -> no ack, busy=0 next cycle, word 0x20 unchanged.
REQ-036 req held high after ack for 5 cycles -> single ack, busy high until req low, then IDLE.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared types and constants for the memory bus responder: FSM state encoding,
// default wait-state count, and the address-check widths.
package mem_bus_responder_pkg;

    localparam int unsigned AddrWidth      = 32;
    localparam int unsigned DataWidth      = 32;
    localparam int unsigned AlignBits      = 2;
    localparam int unsigned CntWidth       = 4;
    localparam int unsigned WaitCycDefault = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2,
        StDone = 2'd3
    } state_e;

    // Rejects misaligned byte addresses and addresses beyond the word RAM.
    function automatic logic addr_err(input logic [AddrWidth-1:0] addr,
                                      input int unsigned depth_log2);
        logic [AddrWidth-1:0] hi_mask;
        hi_mask = ~((AddrWidth'(1) << (depth_log2 + AlignBits)) - AddrWidth'(1));
        return (addr[AlignBits-1:0] != '0) || ((addr & hi_mask) != '0);
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Four-phase request/acknowledge bus between an initiator (master) and the
// responder (slave).
interface mem_bus_responder_if;
    import mem_bus_responder_pkg::*;

    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic                 ack;
    logic                 err;
    logic [DataWidth-1:0] rdata;
    logic                 busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata, busy
    );

endinterface

// File: rtl/mem_word_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset so
// contents survive a responder reset.
module mem_word_ram
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DataWidth-1:0]  wdata,
    output logic [DataWidth-1:0]  rdata
);

    logic [DataWidth-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory bus responder: captures a four-phase request, inserts WAIT_CYC wait
// states, then acknowledges a load/store against a word RAM.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYC   = WaitCycDefault,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_responder_if.slave   bus
);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  we_q;
    logic                  err_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DataWidth-1:0]  wdata_q;
    logic [DataWidth-1:0]  rdata_q;
    logic [DataWidth-1:0]  ram_rdata;
    logic [DataWidth-1:0]  load_val;
    logic                  ram_we;
    logic                  capture;

    assign capture  = (state_q == StIdle) && bus.req;
    assign load_val = err_q ? '0 : ram_rdata;
    // A reset landing on the ACK cycle suppresses the write as well as the ack.
    assign ram_we   = (state_q == StAck) && we_q && !err_q && !rst;

    mem_word_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (capture) begin
                we_q    <= bus.we;
                err_q   <= addr_err(bus.addr, DEPTH_LOG2);
                idx_q   <= bus.addr[DEPTH_LOG2+1:2];
                wdata_q <= bus.wdata;
            end
            if ((state_q == StAck) && !we_q) begin
                rdata_q <= load_val;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    cnt_d   = CntWidth'(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? StAck : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntWidth'(1);
                if (cnt_q <= CntWidth'(1)) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StDone;
            end
            StDone: begin
                // Wait for the request to drop so one high phase yields one ack.
                if (!bus.req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
        bus.busy  = 1'b0;
        bus.rdata = rdata_q;
        if ((state_q == StAck) && !rst) begin
            bus.ack = 1'b1;
            bus.err = err_q;
        end
        if (state_q != StIdle) begin
            bus.busy = 1'b1;
        end
        // Load data shows in the ack cycle itself and is then held by rdata_q.
        if ((state_q == StAck) && !we_q) begin
            bus.rdata = load_val;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a default-latency instance and a
// zero-wait instance sharing clock and reset.
module tb_mem_bus_responder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mem_bus_responder_if bus ();
    mem_bus_responder_if bus_z ();

    mem_bus_responder #(
        .WAIT_CYC   (2),
        .DEPTH_LOG2 (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_bus_responder #(
        .WAIT_CYC   (0),
        .DEPTH_LOG2 (6)
    ) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer on the default instance; lat is the ack cycle counted from
    // the capturing edge (1 = cycle right after it), -1 on timeout.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] r);
        lat = -1;
        e   = 1'bx;
        r   = 'x;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ack) begin
                lat = k;
                e   = bus.err;
                r   = bus.rdata;
                break;
            end
        end
        bus.req = 1'b0;
        for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus_z.req = 1'b1;
        bus_z.we  = 1'b0;
        bus_z.addr  = 32'h0;
        bus_z.wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", bus.ack); else n_pass++;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bus.rdata); else n_pass++;
        n_checks++; if (bus_z.busy !== 1'b0) $display("FAIL reset_busy_z got=%b exp=0", bus_z.busy); else n_pass++;
        bus.req   = 1'b0;
        bus_z.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_no_capture busy=%b exp=0", bus.busy); else n_pass++;
    endtask

    task automatic test_store_load();
        int lat; logic e; logic [31:0] r;
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, lat, e, r);
        n_checks++; if (lat !== 3) $display("FAIL store_lat got=%0d exp=3", lat); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL store_err got=%b exp=0", e); else n_pass++;
        xfer(1'b0, 32'h10, 32'h0, lat, e, r);
        n_checks++; if (lat !== 3) $display("FAIL load_lat got=%0d exp=3", lat); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL load_err got=%b exp=0", e); else n_pass++;
        n_checks++; if (r !== 32'hDEAD_BEEF) $display("FAIL load_rdata got=%h exp=deadbeef", r); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.rdata !== 32'hDEAD_BEEF) $display("FAIL rdata_hold got=%h exp=deadbeef", bus.rdata); else n_pass++;
    endtask

    task automatic test_misaligned();
        int lat; logic e; logic [31:0] r;
        xfer(1'b0, 32'h102, 32'h0, lat, e, r);
        n_checks++; if (lat !== 3) $display("FAIL mis_lat got=%0d exp=3", lat); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL mis_err got=%b exp=1", e); else n_pass++;
        n_checks++; if (r !== 32'h0) $display("FAIL mis_rdata got=%h exp=0", r); else n_pass++;
        xfer(1'b1, 32'h12, 32'h5555_5555, lat, e, r);
        n_checks++; if (e !== 1'b1) $display("FAIL mis_store_err got=%b exp=1", e); else n_pass++;
        xfer(1'b0, 32'h10, 32'h0, lat, e, r);
        n_checks++; if (r !== 32'hDEAD_BEEF) $display("FAIL mis_no_write got=%h exp=deadbeef", r); else n_pass++;
    endtask

    task automatic test_out_of_range();
        int lat; logic e; logic [31:0] r;
        xfer(1'b1, 32'h0, 32'hA5A5_0001, lat, e, r);
        n_checks++; if (e !== 1'b0) $display("FAIL word0_store_err got=%b exp=0", e); else n_pass++;
        xfer(1'b1, 32'h400, 32'hFFFF_FFFF, lat, e, r);
        n_checks++; if (e !== 1'b1) $display("FAIL oor_err got=%b exp=1", e); else n_pass++;
        xfer(1'b0, 32'h0, 32'h0, lat, e, r);
        n_checks++; if (e !== 1'b0) $display("FAIL oor_load_err got=%b exp=0", e); else n_pass++;
        n_checks++; if (r !== 32'hA5A5_0001) $display("FAIL oor_no_write got=%h exp=a5a50001", r); else n_pass++;
    endtask

    task automatic test_capture_hold();
        int lat; logic e; logic [31:0] r;
        lat = -1;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h30; bus.wdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0; bus.addr = 32'h34; bus.wdata = 32'h0;
        if (bus.ack) lat = 1;
        for (int k = 2; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.ack) lat = k;
        end
        bus.req = 1'b0;
        for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
        n_checks++; if (lat !== 3) $display("FAIL hold_lat got=%0d exp=3", lat); else n_pass++;
        xfer(1'b0, 32'h30, 32'h0, lat, e, r);
        n_checks++; if (r !== 32'h1111_2222) $display("FAIL hold_rdata got=%h exp=11112222", r); else n_pass++;
    endtask

    task automatic test_rst_in_wait();
        int lat; logic e; logic [31:0] r; int acks;
        xfer(1'b1, 32'h20, 32'h2020_2020, lat, e, r);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hFFFF_0000;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL rstw_busy_pre got=%b exp=1", bus.busy); else n_pass++;
        rst = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstw_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if (bus.ack !== 1'b0) $display("FAIL rstw_ack got=%b exp=0", bus.ack); else n_pass++;
        n_checks++; if (bus.rdata !== 32'h0) $display("FAIL rstw_rdata got=%h exp=0", bus.rdata); else n_pass++;
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack) acks++;
        end
        n_checks++; if (acks !== 0) $display("FAIL rstw_no_ack got=%0d exp=0", acks); else n_pass++;
        xfer(1'b0, 32'h20, 32'h0, lat, e, r);
        n_checks++; if (r !== 32'h2020_2020) $display("FAIL rstw_word got=%h exp=20202020", r); else n_pass++;
    endtask

    task automatic test_req_hold();
        int lat; int acks; int busy_hi;
        lat = -1; acks = 0; busy_hi = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h20;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ack) begin
                lat = k;
                break;
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (bus.ack) acks++;
            if (bus.busy) busy_hi++;
        end
        bus.req = 1'b0;
        @(negedge clk);
        n_checks++; if (lat !== 3) $display("FAIL hold_req_lat got=%0d exp=3", lat); else n_pass++;
        n_checks++; if (acks !== 0) $display("FAIL hold_req_extra_ack got=%0d exp=0", acks); else n_pass++;
        n_checks++; if (busy_hi !== 5) $display("FAIL hold_req_busy got=%0d exp=5", busy_hi); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL hold_req_idle busy=%b exp=0", bus.busy); else n_pass++;
    endtask

    task automatic test_req_drop();
        int lat; logic [31:0] r;
        lat = -1; r = 'x;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ack) begin
                lat = k;
                r   = bus.rdata;
            end
            if (k == 1) bus.req = 1'b0;
            if (lat >= 0) break;
        end
        repeat (2) @(negedge clk);
        n_checks++; if (lat !== 3) $display("FAIL drop_lat got=%0d exp=3", lat); else n_pass++;
        n_checks++; if (r !== 32'hDEAD_BEEF) $display("FAIL drop_rdata got=%h exp=deadbeef", r); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL drop_idle busy=%b exp=0", bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic        w_t [4];
        logic [31:0] a_t [4];
        logic [31:0] d_t [4];
        logic [31:0] x_t [4];
        w_t[0] = 1'b1; a_t[0] = 32'h8; d_t[0] = 32'hCAFE_0008; x_t[0] = 32'h0;
        w_t[1] = 1'b1; a_t[1] = 32'hC; d_t[1] = 32'h0000_000C; x_t[1] = 32'h0;
        w_t[2] = 1'b0; a_t[2] = 32'h8; d_t[2] = 32'h0;         x_t[2] = 32'hCAFE_0008;
        w_t[3] = 1'b0; a_t[3] = 32'hC; d_t[3] = 32'h0;         x_t[3] = 32'h0000_000C;
        for (int t = 0; t < 4; t++) begin
            int lat; int acks; logic [31:0] r;
            lat = -1; acks = 0; r = 'x;
            @(negedge clk);
            bus_z.req = 1'b1; bus_z.we = w_t[t]; bus_z.addr = a_t[t]; bus_z.wdata = d_t[t];
            @(posedge clk);
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (bus_z.ack) begin
                    acks++;
                    lat = k;
                    r   = bus_z.rdata;
                    break;
                end
            end
            bus_z.req = 1'b0;
            for (int i = 0; i < 10 && bus_z.busy; i++) begin
                @(negedge clk);
                if (bus_z.ack) acks++;
            end
            n_checks++; if (lat !== 1) $display("FAIL b2b_lat[%0d] got=%0d exp=1", t, lat); else n_pass++;
            n_checks++; if (acks !== 1) $display("FAIL b2b_acks[%0d] got=%0d exp=1", t, acks); else n_pass++;
            if (!w_t[t]) begin
                n_checks++;
                if (r !== x_t[t]) $display("FAIL b2b_rdata[%0d] got=%h exp=%h", t, r, x_t[t]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_capture_hold();
        test_rst_in_wait();
        test_req_hold();
        test_req_drop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
